// File: rtl/store_buffer_responder_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_responder_pkg
// Shared definitions for the store buffer responder: default geometry, the
// MMIO GPIO register address, the buffered store entry layout and the store
// classification helper used by the top level.
// -----------------------------------------------------------------------------
package store_buffer_responder_pkg;

    localparam int          DEFAULT_DEPTH     = 4;
    localparam logic [31:0] DEFAULT_MMIO_ADDR = 32'hFFFF_0000;
    localparam int          ENTRY_W           = 64;

    // One buffered store: address in the upper word, data in the lower word.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } storeEntry_t;

    typedef enum logic [1:0] {
        STORE_NONE,
        STORE_MISALIGNED,
        STORE_MMIO,
        STORE_BUFFERED
    } storeKind_e;

    // Misalignment is checked before the MMIO match, so a misaligned access
    // near the GPIO address is still rejected as misaligned.
    function automatic storeKind_e classifyStore(
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] mmioAddr
    );
        if (!we)                    return STORE_NONE;
        else if (addr[1:0] != 2'b0) return STORE_MISALIGNED;
        else if (addr == mmioAddr)  return STORE_MMIO;
        else                        return STORE_BUFFERED;
    endfunction

endpackage

// File: rtl/store_buffer_responder_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head read. Pointers wrap modulo
// DEPTH (a power of two); the occupancy count tells full from empty.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   push       write wrData at the tail (ignored when full with no pop)
//   pop        advance the head (ignored when empty)
//   wrData     entry to push
//   rdData     current head entry
//   count      occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wrData,
    output logic [WIDTH-1:0]       rdData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == FULL_COUNT);
    assign doPop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign doPush = push && (!full || doPop);
    assign rdData = storage[rdPtr];

    // NOTE: storage has no reset; the count gates every read, so stale
    // contents are never observed and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (doPush) begin
            storage[wrPtr] <= wrData;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_buffer_responder.sv
// -----------------------------------------------------------------------------
// store_buffer_responder
// Accepts core stores one per cycle. Misaligned stores are dropped and flagged,
// stores to MMIO_ADDR update the GPIO output register, and all others are
// queued in a FIFO that drains to backing memory through a valid/ready port.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   addr, data, we            core store request
//   err_clr                   synchronous clear of the sticky error flags
//   mem_wvalid/wready         backing-memory write handshake
//   mem_waddr, mem_wdata      head entry of the store FIFO
//   full, count               FIFO status
//   gpio_out                  MMIO output register
//   store_cnt                 accepted (buffered + MMIO) store counter, wraps
//   ovf_err, misalign_err     sticky drop flags
// -----------------------------------------------------------------------------
module store_buffer_responder
    import store_buffer_responder_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [31:0] MMIO_ADDR = DEFAULT_MMIO_ADDR
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            addr,
    input  logic [31:0]            data,
    input  logic                   we,
    input  logic                   err_clr,
    output logic                   mem_wvalid,
    input  logic                   mem_wready,
    output logic [31:0]            mem_waddr,
    output logic [31:0]            mem_wdata,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            gpio_out,
    output logic [15:0]            store_cnt,
    output logic                   ovf_err,
    output logic                   misalign_err
);

    storeKind_e  kind;
    logic        isMisaligned;
    logic        isMmio;
    logic        isBuffered;
    logic        popFire;
    logic        pushAccept;
    logic        ovfHit;
    logic        fifoEmpty;
    storeEntry_t tailEntry;
    storeEntry_t headEntry;

    assign kind = classifyStore(we, addr, MMIO_ADDR);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        isMisaligned = 1'b0;
        isMmio       = 1'b0;
        isBuffered   = 1'b0;
        case (kind)
            STORE_MISALIGNED: isMisaligned = 1'b1;
            STORE_MMIO:       isMmio       = 1'b1;
            STORE_BUFFERED:   isBuffered   = 1'b1;
            default:          ;
        endcase
    end

    assign popFire    = mem_wvalid && mem_wready;
    assign pushAccept = isBuffered && (!full || popFire);
    assign ovfHit     = isBuffered && full && !popFire;
    assign tailEntry  = '{addr: addr, data: data};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) storeFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (pushAccept),
        .pop    (popFire),
        .wrData (tailEntry),
        .rdData (headEntry),
        .count  (count),
        .full   (full),
        .empty  (fifoEmpty)
    );

    // Derived from the asynchronously reset count, so reset drops it at once.
    assign mem_wvalid = !fifoEmpty;
    assign mem_waddr  = headEntry.addr;
    assign mem_wdata  = headEntry.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out     <= '0;
            store_cnt    <= '0;
            ovf_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (isMmio) gpio_out <= data;
            if (isMmio || pushAccept) store_cnt <= store_cnt + 16'd1;
            // A fresh error on the clearing edge keeps its flag set.
            ovf_err      <= ovfHit       || (ovf_err      && !err_clr);
            misalign_err <= isMisaligned || (misalign_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_store_buffer_responder.sv
// -----------------------------------------------------------------------------
// tb_store_buffer_responder
// Drives directed and randomized stores into store_buffer_responder (DEPTH=4)
// and compares every output each cycle against a queue-based model of the
// store buffer, plus literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_store_buffer_responder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] MMIO  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        err_clr;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        full;
    logic [2:0]  count;
    logic [31:0] gpio_out;
    logic [15:0] store_cnt;
    logic        ovf_err;
    logic        misalign_err;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model
    logic [63:0] mQ[$];
    logic [31:0] mGpio;
    logic [15:0] mCnt;
    logic        mOvf;
    logic        mMis;

    store_buffer_responder #(.DEPTH(DEPTH), .MMIO_ADDR(MMIO)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .data         (data),
        .we           (we),
        .err_clr      (err_clr),
        .mem_wvalid   (mem_wvalid),
        .mem_wready   (mem_wready),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .full         (full),
        .count        (count),
        .gpio_out     (gpio_out),
        .store_cnt    (store_cnt),
        .ovf_err      (ovf_err),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelStep();
        logic popNow;
        logic ovfHit;
        logic misHit;
        if (rst) begin
            mQ.delete();
            mGpio = '0;
            mCnt  = '0;
            mOvf  = 1'b0;
            mMis  = 1'b0;
            return;
        end
        popNow = (mQ.size() != 0) && mem_wready;
        ovfHit = 1'b0;
        misHit = 1'b0;
        if (popNow) void'(mQ.pop_front());
        if (we) begin
            if (addr[1:0] != 2'b00) begin
                misHit = 1'b1;
            end else if (addr == MMIO) begin
                mGpio = data;
                mCnt  = mCnt + 16'd1;
            end else if (mQ.size() < DEPTH) begin
                mQ.push_back({addr, data});
                mCnt = mCnt + 16'd1;
            end else begin
                ovfHit = 1'b1;
            end
        end
        mOvf = ovfHit | (mOvf & ~err_clr);
        mMis = misHit | (mMis & ~err_clr);
    endtask

    task automatic compareAll();
        logic [63:0] head;
        check("mem_wvalid", 64'(mem_wvalid), 64'(mQ.size() != 0));
        if (mQ.size() != 0) begin
            head = mQ[0];
            check("mem_waddr", 64'(mem_waddr), 64'(head[63:32]));
            check("mem_wdata", 64'(mem_wdata), 64'(head[31:0]));
        end
        check("count", 64'(count), 64'(mQ.size()));
        check("full", 64'(full), 64'(mQ.size() == DEPTH));
        check("gpio_out", 64'(gpio_out), 64'(mGpio));
        check("store_cnt", 64'(store_cnt), 64'(mCnt));
        check("ovf_err", 64'(ovf_err), 64'(mOvf));
        check("misalign_err", 64'(misalign_err), 64'(mMis));
    endtask

    // One clock: model the edge, let it happen, compare on the falling edge.
    task automatic cycle();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, input logic clr);
        we         = w;
        addr       = a;
        data       = d;
        mem_wready = rdy;
        err_clr    = clr;
        cycle();
    endtask

    task automatic doReset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        rst        = 1'b1;
        we         = 1'b0;
        addr       = '0;
        data       = '0;
        mem_wready = 1'b0;
        err_clr    = 1'b0;
        @(negedge clk);

        // Reset state
        doReset();
        check("rst_count", 64'(count), 64'd0);
        check("rst_wvalid", 64'(mem_wvalid), 64'd0);
        check("rst_store_cnt", 64'(store_cnt), 64'd0);

        // Three stores, continuous drain: head is the latest store each cycle
        drive(1'b1, 32'h100, 32'hA, 1'b1, 1'b0);
        check("seq_addr0", 64'(mem_waddr), 64'h100);
        check("seq_data0", 64'(mem_wdata), 64'hA);
        drive(1'b1, 32'h104, 32'hB, 1'b1, 1'b0);
        check("seq_addr1", 64'(mem_waddr), 64'h104);
        check("seq_data1", 64'(mem_wdata), 64'hB);
        drive(1'b1, 32'h108, 32'hC, 1'b1, 1'b0);
        check("seq_addr2", 64'(mem_waddr), 64'h108);
        check("seq_data2", 64'(mem_wdata), 64'hC);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check("seq_drained", 64'(mem_wvalid), 64'd0);
        check("seq_store_cnt", 64'(store_cnt), 64'd3);

        // Overflow: five stores with memory stalled
        doReset();
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h200 + 32'(4 * i), 32'h20 + 32'(i), 1'b0, 1'b0);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_flag", 64'(ovf_err), 64'd1);
        check("ovf_store_cnt", 64'(store_cnt), 64'd4);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 64'(ovf_err), 64'd0);

        // Full FIFO with same-edge pop accepts the store
        drive(1'b1, 32'h300, 32'h30, 1'b1, 1'b0);
        check("fullpush_count", 64'(count), 64'd4);
        check("fullpush_ovf", 64'(ovf_err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            a = (i < 3) ? 32'h204 + 32'(4 * i) : 32'h300;
            check("drain_addr", 64'(mem_waddr), 64'(a));
            drive(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check("drain_empty", 64'(mem_wvalid), 64'd0);

        // MMIO, misaligned, error clear
        doReset();
        drive(1'b1, MMIO, 32'h55, 1'b1, 1'b0);
        check("mmio_gpio", 64'(gpio_out), 64'h55);
        check("mmio_count", 64'(count), 64'd0);
        check("mmio_store_cnt", 64'(store_cnt), 64'd1);
        drive(1'b1, 32'h102, 32'h66, 1'b1, 1'b0);
        check("mis_flag", 64'(misalign_err), 64'd1);
        check("mis_count", 64'(count), 64'd0);
        drive(1'b1, 32'h103, 32'h67, 1'b1, 1'b1);
        check("mis_clr_race", 64'(misalign_err), 64'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        check("mis_cleared", 64'(misalign_err), 64'd0);

        // Stall holds head stable; reset mid-wait empties at once
        doReset();
        drive(1'b1, 32'h400, 32'h44, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            check("stall_addr", 64'(mem_waddr), 64'h400);
            check("stall_data", 64'(mem_wdata), 64'h44);
        end
        #2 rst = 1'b1;
        #1;
        check("async_wvalid", 64'(mem_wvalid), 64'd0);
        check("async_count", 64'(count), 64'd0);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        drive(1'b1, 32'h500, 32'h55, 1'b0, 1'b0);
        check("first_after_rst", 64'(mem_waddr), 64'h500);

        // Randomized mix of traffic
        doReset();
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = {$urandom_range(0, 32'h3FFF_FFFF) << 2} | 32'($urandom_range(1, 3));
            else if (r == 1) a = MMIO;
            else             a = 32'h1000_0000 | (32'($urandom_range(0, 1023)) << 2);
            drive(($urandom % 4) != 0, a, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
        end

        // Counter and pointer wrap under continuous drain
        doReset();
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 32'h2000_0000 | (32'(i % 4096) << 2), $urandom, 1'b1, 1'b0);
        end
        check("wrap_store_cnt", 64'(store_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
